// File: rtl/bsg_cache_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_cache_pkt_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one bsg_cache packet port among
//             num_req_p requesters. Granted packets pass through one output
//             register toward the cache; an ID FIFO remembers which requester
//             owns each outstanding packet so in-order responses are routed
//             back to their owners.
//  Ports    : clk_i, reset_i (async, active-high)
//             req_v_i / req_pkt_i / req_yumi_o       - requester packet side
//             cache_pkt_v_o / cache_pkt_o / cache_pkt_ready_i - cache packet
//             cache_v_i / cache_data_i / cache_yumi_o - cache response side
//             resp_v_o / resp_data_o / resp_ready_i   - requester responses
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_cache_pkt_rr_arbiter #(
  parameter int num_req_p    = 4,
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int els_p        = 4,
  localparam int pkt_width_lp = 5 + addr_width_p + data_width_p + data_width_p/8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,

  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*pkt_width_lp-1:0] req_pkt_i,
  output logic [num_req_p-1:0]              req_yumi_o,

  output logic                              cache_pkt_v_o,
  output logic [pkt_width_lp-1:0]           cache_pkt_o,
  input  logic                              cache_pkt_ready_i,

  input  logic                              cache_v_i,
  input  logic [data_width_p-1:0]           cache_data_i,
  output logic                              cache_yumi_o,

  output logic [num_req_p-1:0]              resp_v_o,
  output logic [data_width_p-1:0]           resp_data_o,
  input  logic [num_req_p-1:0]              resp_ready_i
);

  localparam int id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);

  localparam logic [id_width_lp-1:0]  last_reset_lp = id_width_lp'(num_req_p - 1);
  localparam logic [ptr_width_lp-1:0] ptr_last_lp   = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] cnt_full_lp   = cnt_width_lp'(els_p);
  localparam logic [num_req_p-1:0]    one_hot_lsb   = num_req_p'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [id_width_lp-1:0]  last_r;
  logic [id_width_lp-1:0]  id_mem [els_p];
  logic [ptr_width_lp-1:0] rd_ptr;
  logic [ptr_width_lp-1:0] wr_ptr;
  logic [cnt_width_lp-1:0] count;

  logic fifo_full;
  logic fifo_empty;
  logic stage_free;
  logic grant;
  logic fifo_pop;
  logic resp_fire_v;
  logic [id_width_lp-1:0] head_id;
  logic [id_width_lp-1:0] grant_idx;
  logic                   grant_found;
  logic [id_width_lp-1:0] cand_idx;
  int                     cand;

  assign fifo_full  = (count == cnt_full_lp);
  assign fifo_empty = (count == '0);
  assign stage_free = ~cache_pkt_v_o | cache_pkt_ready_i;

  // --------------------------------------------------------------------------
  // Round-robin search starting one past the last granted requester
  // --------------------------------------------------------------------------
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_r;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= num_req_p; k++) begin
      cand     = (int'(last_r) + k) % num_req_p;
      cand_idx = id_width_lp'(cand);
      if (!grant_found && req_v_i[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // The full check deliberately ignores a same-cycle pop: no bypass path.
  // Gating with reset_i keeps the yumi low while the design is held in reset.
  assign grant      = ~reset_i & stage_free & ~fifo_full & grant_found;
  assign req_yumi_o = grant ? (one_hot_lsb << grant_idx) : '0;

  // --------------------------------------------------------------------------
  // Response routing from the ID FIFO head
  // --------------------------------------------------------------------------
  assign head_id      = id_mem[rd_ptr];
  assign resp_fire_v  = cache_v_i & ~fifo_empty & ~reset_i;
  assign resp_v_o     = resp_fire_v ? (one_hot_lsb << head_id) : '0;
  assign resp_data_o  = cache_data_i;
  assign cache_yumi_o = resp_fire_v & resp_ready_i[head_id];
  assign fifo_pop     = cache_yumi_o;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_last_lp) ? '0 : p + ptr_width_lp'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Output packet register and round-robin pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cache_pkt_v_o <= 1'b0;
      cache_pkt_o   <= '0;
      last_r        <= last_reset_lp;
    end else if (grant) begin
      cache_pkt_v_o <= 1'b1;
      cache_pkt_o   <= req_pkt_i[grant_idx*pkt_width_lp +: pkt_width_lp];
      last_r        <= grant_idx;
    end else if (cache_pkt_ready_i) begin
      // Accepted with nothing new behind it; payload is left as-is.
      cache_pkt_v_o <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // ID FIFO control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant)    wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({grant, fifo_pop})
        2'b10:   count <= count + cnt_width_lp'(1);
        2'b01:   count <= count - cnt_width_lp'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk_i) begin
    if (grant) id_mem[wr_ptr] <= grant_idx;
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding means the cache broke the protocol.
  a_no_resp_when_empty: assert property (
    @(posedge clk_i) disable iff (reset_i) !(cache_v_i && fifo_empty));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_cache_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_cache_pkt_rr_arbiter
//  Purpose  : Self-checking bench for bsg_cache_pkt_rr_arbiter. Directed
//             scenarios plus a randomized run, all compared each cycle against
//             a queue-based reference model of the arbiter's behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_cache_pkt_rr_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int ELS = 4;
  localparam int PW  = 5 + AW + DW + DW/8;
  localparam int VW  = N + N + 1 + 1 + PW + DW;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [N-1:0]      req_v;
  logic [N*PW-1:0]   req_pkt;
  logic [N-1:0]      req_yumi_o;
  logic              cache_pkt_v_o;
  logic [PW-1:0]     cache_pkt_o;
  logic              ready;
  logic              cache_v;
  logic [DW-1:0]     cache_data;
  logic              cache_yumi_o;
  logic [N-1:0]      resp_v_o;
  logic [DW-1:0]     resp_data_o;
  logic [N-1:0]      resp_ready;

  bsg_cache_pkt_rr_arbiter #(
    .num_req_p(N), .addr_width_p(AW), .data_width_p(DW), .els_p(ELS)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_v_i(req_v), .req_pkt_i(req_pkt), .req_yumi_o(req_yumi_o),
    .cache_pkt_v_o(cache_pkt_v_o), .cache_pkt_o(cache_pkt_o),
    .cache_pkt_ready_i(ready),
    .cache_v_i(cache_v), .cache_data_i(cache_data), .cache_yumi_o(cache_yumi_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_ready_i(resp_ready)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int            q[$];      // owners of outstanding packets, oldest first
  int            m_last;
  bit            m_pv;
  logic [PW-1:0] m_pkt;
  bit            e_grant;
  int            e_win;
  logic [N-1:0]  e_yumi;
  logic [N-1:0]  e_resp_v;
  bit            e_cyumi;

  task automatic model_reset();
    q.delete();
    m_last = N - 1;
    m_pv   = 0;
    m_pkt  = '0;
  endtask

  task automatic model_eval();
    bit free;
    int c;
    free  = !m_pv || ready;
    e_win = -1;
    if (free && q.size() < ELS)
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (req_v[c] && e_win < 0) e_win = c;
      end
    e_grant  = (e_win >= 0);
    e_yumi   = e_grant ? (N'(1) << e_win) : '0;
    e_resp_v = (cache_v && q.size() > 0) ? (N'(1) << q[0]) : '0;
    e_cyumi  = cache_v && q.size() > 0 && resp_ready[q[0]];
  endtask

  task automatic model_clock();
    if (e_cyumi) void'(q.pop_front());
    if (e_grant) begin
      q.push_back(e_win);
      m_last = e_win;
      m_pv   = 1;
      m_pkt  = req_pkt[e_win*PW +: PW];
    end else if (ready) begin
      m_pv = 0;
    end
  endtask

  function automatic logic [VW-1:0] obs_vec();
    return {req_yumi_o, resp_v_o, cache_yumi_o, cache_pkt_v_o, cache_pkt_o, resp_data_o};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_yumi, e_resp_v, e_cyumi, m_pv, m_pkt, cache_data};
  endfunction

  task automatic rand_pkts();
    logic [95:0] t;
    for (int i = 0; i < N; i++) begin
      t = {$urandom, $urandom, $urandom};
      req_pkt[i*PW +: PW] = t[PW-1:0];
    end
  endtask

  task automatic do_reset();
    reset_i    = 1'b1;
    req_v      = '0;
    ready      = 1'b1;
    cache_v    = 1'b0;
    cache_data = '0;
    resp_ready = '1;
    rand_pkts();
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [PW-1:0] prev_pkt;
    do_reset();
    @(negedge clk_i);
    n_checks++;
    if ({cache_pkt_v_o, cache_pkt_o, req_yumi_o, resp_v_o, cache_yumi_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got pv=%b pkt=%h yumi=%b resp_v=%b cyumi=%b want all 0",
               cache_pkt_v_o, cache_pkt_o, req_yumi_o, resp_v_o, cache_yumi_o);
    end
    @(posedge clk_i); #1;
    prev_pkt = '0;
    req_v = '1;
    for (int c = 0; c < 10; c++) begin
      rand_pkts();
      cache_v    = (q.size() > 0);
      cache_data = $urandom;
      @(negedge clk_i); model_eval();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rr_model c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      n_checks++;
      if (req_yumi_o !== (N'(1) << (c % N))) begin
        n_fail++; $display("FAIL rr_order c=%0d got %b want %b", c, req_yumi_o, N'(1) << (c % N));
      end
      if (c > 0) begin
        n_checks++;
        if (cache_pkt_v_o !== 1'b1 || cache_pkt_o !== prev_pkt) begin
          n_fail++; $display("FAIL pkt_latency c=%0d got v=%b %h want v=1 %h", c, cache_pkt_v_o, cache_pkt_o, prev_pkt);
        end
      end
      prev_pkt = req_pkt[(c % N)*PW +: PW];
      @(posedge clk_i); model_clock(); #1;
    end
  endtask

  task automatic test_stall();
    logic [PW-1:0] held;
    do_reset();
    req_v = '1;
    @(negedge clk_i); model_eval();
    held = req_pkt[PW-1:0];
    @(posedge clk_i); model_clock(); #1;
    ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_pkts();
      @(negedge clk_i); model_eval();
      n_checks++;
      if (req_yumi_o !== '0 || cache_pkt_o !== held || cache_pkt_v_o !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold c=%0d got yumi=%b pkt=%h want yumi=0 pkt=%h", c, req_yumi_o, cache_pkt_o, held);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stall_model c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      @(posedge clk_i); model_clock(); #1;
    end
    ready = 1'b1;
    @(negedge clk_i); model_eval();
    n_checks++;
    if (req_yumi_o !== 4'b0010) begin
      n_fail++; $display("FAIL stall_release_grant got %b want 0010", req_yumi_o);
    end
    held = req_pkt[PW +: PW];
    @(posedge clk_i); model_clock(); #1;
    req_v = '0;
    @(negedge clk_i); model_eval();
    n_checks++;
    if (cache_pkt_o !== held || cache_pkt_v_o !== 1'b1) begin
      n_fail++; $display("FAIL stall_next_pkt got %h want %h", cache_pkt_o, held);
    end
    @(posedge clk_i); model_clock(); #1;
  endtask

  task automatic test_fifo_full();
    logic [N-1:0] want;
    do_reset();
    req_v = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      rand_pkts();
      cache_v    = (c == 5);
      cache_data = $urandom;
      want       = (c == 4 || c == 5) ? 4'b0000 : 4'b0010;
      @(negedge clk_i); model_eval();
      n_checks++;
      if (req_yumi_o !== want) begin
        n_fail++; $display("FAIL fifo_full_grant c=%0d got %b want %b", c, req_yumi_o, want);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL fifo_full_model c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      @(posedge clk_i); model_clock(); #1;
    end
  endtask

  task automatic test_routing();
    logic [N-1:0]  order [3];
    logic [DW-1:0] datas [3];
    order = '{4'b0100, 4'b0001, 4'b0100};
    datas = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req_v = order[c];
      rand_pkts();
      @(negedge clk_i); model_eval();
      n_checks++;
      if (req_yumi_o !== order[c]) begin
        n_fail++; $display("FAIL route_grant c=%0d got %b want %b", c, req_yumi_o, order[c]);
      end
      @(posedge clk_i); model_clock(); #1;
    end
    req_v = '0;
    for (int c = 0; c < 3; c++) begin
      cache_v    = 1'b1;
      cache_data = datas[c];
      @(negedge clk_i); model_eval();
      n_checks++;
      if (resp_v_o !== order[c] || resp_data_o !== datas[c] || cache_yumi_o !== 1'b1) begin
        n_fail++; $display("FAIL route_resp c=%0d got v=%b d=%h y=%b want v=%b d=%h y=1",
                           c, resp_v_o, resp_data_o, cache_yumi_o, order[c], datas[c]);
      end
      @(posedge clk_i); model_clock(); #1;
    end
    cache_v = 1'b0;
  endtask

  task automatic test_resp_backpressure();
    do_reset();
    req_v = 4'b0010;
    @(negedge clk_i); model_eval(); @(posedge clk_i); model_clock(); #1;
    req_v = 4'b1000;
    @(negedge clk_i); model_eval(); @(posedge clk_i); model_clock(); #1;
    req_v      = '0;
    cache_v    = 1'b1;
    resp_ready = 4'b1101;
    for (int c = 0; c < 2; c++) begin
      cache_data = $urandom;
      @(negedge clk_i); model_eval();
      n_checks++;
      if (cache_yumi_o !== 1'b0 || resp_v_o !== 4'b0010) begin
        n_fail++; $display("FAIL bp_hold c=%0d got y=%b v=%b want y=0 v=0010", c, cache_yumi_o, resp_v_o);
      end
      @(posedge clk_i); model_clock(); #1;
    end
    // Push and pop together at two outstanding.
    resp_ready = '1;
    req_v      = 4'b0001;
    @(negedge clk_i); model_eval();
    n_checks++;
    if (cache_yumi_o !== 1'b1 || req_yumi_o !== 4'b0001) begin
      n_fail++; $display("FAIL bp_push_pop got y=%b yumi=%b want y=1 yumi=0001", cache_yumi_o, req_yumi_o);
    end
    @(posedge clk_i); model_clock(); #1;
    // Two free slots remain: two grants, then blocked.
    cache_v = 1'b0;
    req_v   = '1;
    for (int c = 0; c < 3; c++) begin
      rand_pkts();
      @(negedge clk_i); model_eval();
      n_checks++;
      if (obs_vec() !== exp_vec() || req_yumi_o !== ((c == 2) ? 4'b0000 : (4'b0010 << c))) begin
        n_fail++; $display("FAIL bp_count c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      @(posedge clk_i); model_clock(); #1;
    end
    req_v = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_v = '1;
    for (int c = 0; c < 3; c++) begin
      rand_pkts();
      @(negedge clk_i); model_eval(); @(posedge clk_i); model_clock(); #1;
    end
    #1 reset_i = 1'b1;
    #1;
    n_checks++;
    if (cache_pkt_v_o !== 1'b0 || cache_pkt_o !== '0 || req_yumi_o !== '0) begin
      n_fail++; $display("FAIL midreset_clear got pv=%b pkt=%h yumi=%b want 0", cache_pkt_v_o, cache_pkt_o, req_yumi_o);
    end
    model_reset();
    @(posedge clk_i); #1 reset_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rand_pkts();
      @(negedge clk_i); model_eval();
      n_checks++;
      if (obs_vec() !== exp_vec() || req_yumi_o !== ((c == 4) ? 4'b0000 : (4'b0001 << c))) begin
        n_fail++; $display("FAIL midreset_after c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      @(posedge clk_i); model_clock(); #1;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_v      = N'($urandom);
      ready      = ($urandom_range(0, 3) != 0);
      resp_ready = N'($urandom);
      cache_v    = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      cache_data = $urandom;
      rand_pkts();
      @(negedge clk_i); model_eval();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      @(posedge clk_i); model_clock(); #1;
    end
    cache_v = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stall();
    test_fifo_full();
    test_routing();
    test_resp_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bsg_cache_pkt_rr_arbiter.md
# bsg_cache_pkt_rr_arbiter

Round-robin arbiter that shares one bsg_cache packet port among `num_req_p` requesters and routes each in-order cache response back to the requester that issued the packet. It sits directly in front of the cache's packet input, upstream of packet decode. It has one registered packet stage toward the cache and an ID FIFO that tracks outstanding packets.

## Interface
Parameters:
- `num_req_p`, 4, number of requesters (≥2).
- `addr_width_p`, 32, cache packet address width.
- `data_width_p`, 32, cache data width. Mask width = `data_width_p`/8.
- `pkt_width_lp`, derived, 5 + `addr_width_p` + `data_width_p` + `data_width_p`/8 (73 at defaults). Opcode is in bits [pkt_width_lp-1 -: 5].
- `els_p`, 4, maximum outstanding packets (ID FIFO depth, ≥2).

Ports:
- `clk_i`, in, 1, single clock. All state is on the rising edge.
- `reset_i`, in, 1, asynchronous, active-high reset.
- `req_v_i`, in, `num_req_p`, per-requester packet valid.
- `req_pkt_i`, in, `num_req_p`*`pkt_width_lp`, requester i's packet in slice i.
- `req_yumi_o`, out, `num_req_p`, one-hot. The packet is consumed this cycle.
- `cache_pkt_v_o`, out, 1, the output register holds a packet.
- `cache_pkt_o`, out, `pkt_width_lp`, registered packet.
- `cache_pkt_ready_i`, in, 1, the cache accepts the packet.
- `cache_v_i`, in, 1, cache response valid.
- `cache_data_i`, in, `data_width_p`, response data.
- `cache_yumi_o`, out, 1, the response is consumed.
- `resp_v_o`, out, `num_req_p`, one-hot response valid to the owner.
- `resp_data_o`, out, `data_width_p`, `cache_data_i` broadcast to all requesters.
- `resp_ready_i`, in, `num_req_p`, per-requester response ready.

## Operation
- **Stage free.** The output stage is free when `cache_pkt_v_o`=0 or (`cache_pkt_v_o` & `cache_pkt_ready_i`).
- **Grant.** A grant occurs when the stage is free, the ID FIFO is not full, and any `req_v_i` is set. There is no bypass: a full FIFO blocks the grant even if a pop happens in the same cycle.
- **Round-robin.** Pointer `last_r` holds the last granted index. The search order is `last_r`+1, `last_r`+2, … modulo `num_req_p`. The first valid requester in that order wins. `last_r` updates only on a grant. A lone requester is granted every eligible cycle.
- **On grant to requester g:**
  - `req_yumi_o[g]`=1.
  - The packet slice g loads into the output register.
  - g is pushed into the ID FIFO.
- **Output register.** It holds its contents while `cache_pkt_v_o` & ~`cache_pkt_ready_i` (no change to `cache_pkt_o`). On acceptance with no new grant, it clears `cache_pkt_v_o`.
- **Response routing.** Let h = ID FIFO head.
  - `resp_v_o[h]` = `cache_v_i` & ~fifo_empty. All other bits are 0.
  - `cache_yumi_o` = `cache_v_i` & ~fifo_empty & `resp_ready_i[h]`.
  - The FIFO pops when `cache_yumi_o`=1.
- **Simultaneous push and pop.** Both occur in the same cycle and the count is unchanged. Pointer wrap is modulo `els_p`.
- **Protocol error.** `cache_v_i` while the FIFO is empty is a protocol error. `cache_yumi_o` stays 0 and a simulation assertion fires.
- **No opcode handling.** The arbiter does not interpret opcodes. Every packet is assumed to produce exactly one in-order response.
- **Reset.** `reset_i` asserted at any time, including mid-transfer, clears all state immediately. A packet in flight is dropped, and its requester re-presenting is the requester's responsibility.

## Timing
- **Reset values:**
  - `cache_pkt_v_o`=0.
  - `cache_pkt_o`=0.
  - `last_r`=`num_req_p`-1, so requester 0 has first priority.
  - FIFO empty.
  - `req_yumi_o`=0, `resp_v_o`=0, `cache_yumi_o`=0.
- **Grant timing.** `req_yumi_o` is combinational from `req_v_i`, FIFO full, and the stage state in the same cycle.
- **Request latency.** A packet granted in cycle t appears on `cache_pkt_o` with `cache_pkt_v_o`=1 in cycle t+1, so request-to-cache latency is 1 cycle.
- **Throughput.** One packet per cycle is sustained while the cache is ready and the FIFO is not full.
- **Response latency.** The response path is combinational, 0 cycles. A pop in cycle t frees a FIFO entry for a grant in cycle t+1.
- **In-order pairing.** Responses to requester i return in the order its packets were granted.
- **Backpressure.** With `els_p` outstanding, no grant occurs until one response is consumed.

## Test plan
- **Reset.** Reset, then all four `req_v_i`=1 continuously with the cache always ready → grant order 0,1,2,3,0,…; each packet appears on `cache_pkt_o` one cycle after its `req_yumi_o`.
- **Stall.** Hold `cache_pkt_ready_i`=0 for 3 cycles with a packet loaded → `cache_pkt_o` is stable and no `req_yumi_o` is asserted. Then ready=1 → the next grant occurs in the same cycle as acceptance.
- **FIFO full.**
  - Issue 4 packets with no responses → the 5th request is blocked.
  - Present one response with `resp_ready_i` for its owner=1 → the 5th is granted the next cycle.
- **Routing.** Grant order 2,0,2 → three responses (`cache_data_i` = A, B, C) assert `resp_v_o` = 4'b0100, 4'b0001, 4'b0100 with matching data.
- **Response backpressure.** Owner's `resp_ready_i`=0 → `cache_yumi_o`=0 and the FIFO head is held. Simultaneous push and pop at count 2 → count stays 2.
- **Reset mid-operation.** Assert `reset_i` asynchronously with 3 outstanding and a packet loaded → `cache_pkt_v_o`=0 and the FIFO is empty immediately. Priority returns to requester 0.
